// File: rtl/simu_uart_rx_driver.sv
// Simulation-side UART transmitter driving the SoC UART_RX pin from a byte FIFO (8N1, LSB first).
// Optional even parity bit between data and stop when SIMU_UART_PARITY_EN is defined.
//
// state    | meaning
// IDLE     | line high, waiting for a queued byte and tx_enable
// START    | start bit (line low)
// DATA     | eight data bits, LSB first
// PARITY   | even parity bit (SIMU_UART_PARITY_EN only)
// STOP     | STOP_BITS stop bits (line high)
module simu_uart_rx_driver #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          tx_enable,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          uart_line,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SIMU_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_d;
  logic          push, pop, bit_done, can_start;

  // in_ready looks only at the count, so a pop on a full FIFO cannot admit a push in the same cycle
  assign in_ready   = (count_q < CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE);
  assign bit_done   = (baud_q == BAUD_LAST);
  assign can_start  = (count_q != '0) && tx_enable;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          state_d = S_START;
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef SIMU_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef SIMU_UART_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          if (stop_idx_q == STOP_LAST) begin
            // Chain straight into the next start bit so back-to-back frames have no idle gap
            if (can_start) begin
              state_d = S_START;
              pop     = 1'b1;
              shift_d = mem[rd_ptr];
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || state_q == S_IDLE || bit_done) baud_d = '0;
    else                                                      baud_d = baud_q + BW'(1);

    // Line is registered from the next state so it changes on the same edge as the state
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[bit_idx_d];
`ifdef SIMU_UART_PARITY_EN
      S_PARITY: line_d = ^shift_d;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      uart_line  <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      uart_line  <= line_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q    <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_simu_uart_rx_driver.sv
// Directed bench for simu_uart_rx_driver (CLK_DIV=4, FIFO_DEPTH=8, STOP_BITS=1).
// Parity frames are expected when SIMU_UART_PARITY_EN is defined.
module tb_simu_uart_rx_driver;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int STOP_BITS  = 1;
`ifdef SIMU_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (10 + STOP_BITS - 1 + PAR) * CLK_DIV;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       tx_enable;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       uart_line;
  logic       busy;
  logic [3:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] vec [9] = '{8'h01, 8'h80, 8'hF0, 8'h0F, 8'h33, 8'hCC, 8'h5A, 8'h96, 8'hFF};

  simu_uart_rx_driver #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .STOP_BITS(STOP_BITS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .tx_enable(tx_enable),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .uart_line(uart_line), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected line value for bit slot idx of a frame carrying byte b
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Cycle k of a frame is sampled just after the k-th edge following the accepting edge
  task automatic check_frame(input logic [7:0] b, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      @(posedge aclk); #1;
      chk($sformatf("line_%02h_k%0d", b, k), uart_line, exp_bit(b, (k - 1) / CLK_DIV));
      chk($sformatf("busy_%02h_k%0d", b, k), busy, 1);
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge aclk); #1;
    in_valid = 1'b0;
    in_data  = ~b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b1; tx_enable = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #2 aresetn = 1'b0;

    // Reset
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_line", uart_line, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", fifo_count, 0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("idle_line", uart_line, 1);

    // Single byte
    push(8'h55);
    check_frame(8'h55, 1, FRAME);
    @(posedge aclk); #1;
    chk("single_busy_end", busy, 0);
    chk("single_line_end", uart_line, 1);

    // Back-to-back: push and pop on the second edge keep the count at 1
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge aclk); #1;
    chk("b2b_count1", fifo_count, 1);
    in_data = 8'h3C;
    @(posedge aclk); #1;
    in_valid = 1'b0; in_data = 8'h00;
    chk("b2b_count_pp", fifo_count, 1);
    chk("b2b_line_k1", uart_line, 0);
    check_frame(8'hA5, 2, FRAME);
    check_frame(8'h3C, 1, FRAME);
    @(posedge aclk); #1;
    chk("b2b_busy_end", busy, 0);
    chk("b2b_count_end", fifo_count, 0);

    // FIFO full with transmission disabled
    tx_enable = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = vec[i];
      @(posedge aclk); #1;
      if (i == 6) chk("full_ready7", in_ready, 1);
      if (i == 7) begin
        chk("full_ready8", in_ready, 0);
        chk("full_count8", fifo_count, 8);
      end
    end
    in_valid = 1'b0; in_data = 8'h00;
    chk("full_count9", fifo_count, 8);
    repeat (3) @(posedge aclk);
    #1;
    chk("full_idle_busy", busy, 0);
    chk("full_idle_line", uart_line, 1);
    tx_enable = 1'b1;
    for (int i = 0; i < 8; i++) check_frame(vec[i], 1, FRAME);
    @(posedge aclk); #1;
    chk("full_busy_end", busy, 0);
    chk("full_count_end", fifo_count, 0);

    // Drop tx_enable mid-frame, then reset mid-frame
    in_valid = 1'b1; in_data = 8'h96;
    @(posedge aclk); #1;
    in_data = 8'h69;
    @(posedge aclk); #1;
    in_valid = 1'b0; in_data = 8'h00;
    chk("en_line_k1", uart_line, 0);
    check_frame(8'h96, 2, 10);
    tx_enable = 1'b0;
    check_frame(8'h96, 11, FRAME);
    @(posedge aclk); #1;
    chk("en_busy_end", busy, 0);
    chk("en_count_end", fifo_count, 1);
    repeat (4) @(posedge aclk);
    #1;
    chk("en_hold_busy", busy, 0);
    chk("en_hold_line", uart_line, 1);
    push(8'h11);
    chk("en_count2", fifo_count, 2);
    tx_enable = 1'b1;
    check_frame(8'h69, 1, 2);
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rst_line", uart_line, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_line", uart_line, 1);

`ifdef SIMU_UART_PARITY_EN
    // Parity bits: 0x07 has odd weight, 0x03 even
    push(8'h07);
    check_frame(8'h07, 1, FRAME);
    push(8'h03);
    check_frame(8'h03, 1, FRAME);
    @(posedge aclk); #1;
    chk("par_busy_end", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
